sub_serial: RTL and testbench

// - Bit-serial WIDTH-bit subtractor: result = a - b, computed LSB-first, one bit
//   per clock, through a single full-subtractor cell and a borrow flop.
// - Inverse of the one-bit full adder. Used as the compact arithmetic stage

---
 rtl/sub_serial.sv | 123 ++++++++++++
 tb/tb_sub_serial.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB-first through one full-subtractor cell.
// Optional signed-overflow output enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             bout
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;

    logic             diff_d;
    logic             brw_d;

    // Single full-subtractor cell working on the current LSBs.
    always_comb begin
        diff_d = sa_q[0] ^ sb_q[0] ^ brw_q;
        brw_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
    end

`ifdef SUB_SERIAL_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // On the last bit cycle sa_q[0]/sb_q[0] are the operand sign bits and diff_d is the result sign.
    always_comb begin
        ovf_d = (sa_q[0] != sb_q[0]) & (diff_d != sa_q[0]);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        sa_q    <= a;
                        sb_q    <= b;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    result_q <= {diff_d, result_q[WIDTH-1:1]};
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    brw_q    <= brw_d;
                    if (cnt_q == LAST_BIT) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bout_q  <= brw_d;
`ifdef SUB_SERIAL_OVF_EN
                        ovf_q   <= ovf_d;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign bout   = bout_q;
`ifdef SUB_SERIAL_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Directed-vector bench for sub_serial (WIDTH=8): table of hand-computed differences,
// back-to-back, reset-abort and random sequences.
module tb_sub_serial;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         bout;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf;
`endif

    int checks_total;
    int checks_passed;

    sub_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .bout   (bout)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // One complete operation from IDLE: start pulse, latency, outputs, done pulse width.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_res, input logic exp_bout, input logic exp_ovf);
        int n;
        bit overlap;
        n = 0;
        overlap = 0;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        while (!done && n < 50) begin
            if (busy && done) overlap = 1;
            tick();
            n++;
            a = W'($urandom);
            b = W'($urandom);
        end
        if (busy && done) overlap = 1;
        check("latency", n, W);
        check("busy_done_exclusive", {31'd0, overlap}, 32'd0);
        check("result", {24'd0, result}, {24'd0, exp_res});
        check("bout", {31'd0, bout}, {31'd0, exp_bout});
`ifdef SUB_SERIAL_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`else
        if (exp_ovf) begin end
`endif
        tick();
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("result_held", {23'd0, bout, result}, {23'd0, exp_bout, exp_res});
        $display("op a=%02h b=%02h -> result=%02h bout=%0d (exp %02h/%0d) latency=%0d",
                 av, bv, result, bout, exp_res, exp_bout, n);
    endtask

    initial begin
        int n;
        int dones;
        logic [W:0] full;
        logic [W-1:0] ra, rb;

        checks_total  = 0;
        checks_passed = 0;

        //             a       b       result  bout  ovf
        vecs[0]  = '{8'd100, 8'd37,  8'd63,  1'b0, 1'b0};
        vecs[1]  = '{8'd5,   8'd9,   8'hFC,  1'b1, 1'b0};
        vecs[2]  = '{8'd0,   8'd0,   8'h00,  1'b0, 1'b0};
        vecs[3]  = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
        vecs[4]  = '{8'hFF,  8'h01,  8'hFE,  1'b0, 1'b0};
        vecs[5]  = '{8'h00,  8'h01,  8'hFF,  1'b1, 1'b0};
        vecs[6]  = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
        vecs[7]  = '{8'h01,  8'h80,  8'h81,  1'b1, 1'b1};
        vecs[8]  = '{8'hFF,  8'hFF,  8'h00,  1'b0, 1'b0};
        vecs[9]  = '{8'h55,  8'hAA,  8'hAB,  1'b1, 1'b1};
        vecs[10] = '{8'hC8,  8'h64,  8'h64,  1'b0, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_bout", {31'd0, bout}, 32'd0);
`ifdef SUB_SERIAL_OVF_EN
        check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        tick();

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].bout, vecs[i].ovf);

        // Back-to-back: start held high, a/b scrambled while running.
        a = vecs[0].a;
        b = vecs[0].b;
        start = 1'b1;
        tick();
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin
                tick();
                n++;
                a = W'($urandom);
                b = W'($urandom);
            end while (!done && n < 50);
            check("b2b_period", n, (i == 0) ? W : W + 1);
            check("b2b_result", {23'd0, bout, result}, {23'd0, vecs[i].bout, vecs[i].res});
            $display("b2b op %0d: result=%02h bout=%0d (exp %02h/%0d) cycles=%0d",
                     i, result, bout, vecs[i].res, vecs[i].bout, n);
            a = vecs[i+1].a;
            b = vecs[i+1].b;
        end
        start = 1'b0;
        tick();
        tick();

        // Reset mid-run aborts without a done pulse.
        a = 8'd100;
        b = 8'd37;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", {24'd0, result}, 32'd0);
        check("abort_bout", {31'd0, bout}, 32'd0);
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done || busy) dones++;
        end
        check("abort_no_done", dones, 0);
        $display("reset mid-run: result=%02h busy=%0d stray activity=%0d", result, busy, dones);
        run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0);

        // Reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        a = 8'h80;
        b = 8'h01;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done || busy) dones++;
        end
        check("rst_start_no_run", dones, 0);
        $display("reset+start: busy=%0d stray activity=%0d", busy, dones);

        // Random operands against a wide-subtraction reference.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            full = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, full[W-1:0], full[W],
                   (ra[W-1] != rb[W-1]) && (full[W-1] != ra[W-1]));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
